// File: rtl/grf_scoreboard_pkg.sv
// Shared decode/register-file constants and Tnew/Tuse encodings for the GRF scoreboard.
// Optional build macro SB_STALL_CNT_EN (used by grf_scoreboard) enables the stall counter.
package grf_scoreboard_pkg;

    localparam int NREG         = 32;
    localparam int ADDR_W       = 5;
    localparam int TNEW_W       = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int INFL_W       = 3;

    typedef enum logic [TNEW_W-1:0] {
        T_W = 2'd0,
        T_E = 2'd1,
        T_M = 2'd2
    } tstage_e;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        logic [TNEW_W-1:0] r;
        if (v == {TNEW_W{1'b0}}) begin
            r = v;
        end else begin
            r = v - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/grf_scoreboard_sb_entry.sv
// One register's scoreboard entry: outstanding-write count and cycles-until-result countdown.
module grf_scoreboard_sb_entry
    import grf_scoreboard_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              iss_load_i,
    input  logic [TNEW_W-1:0] iss_tnew_i,
    input  logic              wb_hit_i,
    output logic [INFL_W-1:0] inflight_o,
    output logic [TNEW_W-1:0] cnt_o,
    output logic              err_set_o
);

    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic [TNEW_W-1:0] cnt_q, cnt_d;

    // Next-state for issue, write-back retirement, countdown and squash.
    always_comb begin
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        err_set_o  = 1'b0;
        if (flush_i) begin
            inflight_d = {INFL_W{1'b0}};
            cnt_d      = {TNEW_W{1'b0}};
        end else begin
            err_set_o = wb_hit_i && (inflight_q == {INFL_W{1'b0}});
            if (iss_load_i) begin
                // Newest writer defines readiness; a same-edge retirement cancels the increment.
                cnt_d = iss_tnew_i;
                if (wb_hit_i) begin
                    inflight_d = inflight_q;
                end else begin
                    inflight_d = inflight_q + {{(INFL_W-1){1'b0}}, 1'b1};
                end
            end else if (wb_hit_i && (inflight_q != {INFL_W{1'b0}})) begin
                inflight_d = inflight_q - {{(INFL_W-1){1'b0}}, 1'b1};
                if (inflight_q == {{(INFL_W-1){1'b0}}, 1'b1}) begin
                    cnt_d = {TNEW_W{1'b0}};
                end else begin
                    cnt_d = sat_dec(cnt_q);
                end
            end else if (inflight_q != {INFL_W{1'b0}}) begin
                cnt_d = sat_dec(cnt_q);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Entry state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= {INFL_W{1'b0}};
            cnt_q      <= {TNEW_W{1'b0}};
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    assign inflight_o = inflight_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/grf_scoreboard.sv
// Read-side hazard tracker beside the GRF: stall/forward decisions for decode operands.
// Build macro SB_STALL_CNT_EN adds a free-running stall-cycle counter on stall_cycles.
module grf_scoreboard
    import grf_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [TNEW_W-1:0] iss_tnew,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [TNEW_W-1:0] tuse_rs,
    input  logic [TNEW_W-1:0] tuse_rt,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_a3,
    output logic              stall,
    output logic              fwd_rs,
    output logic              fwd_rt,
    output logic              err,
    output logic [31:0]       stall_cycles
);

    logic [NREG-1:0][INFL_W-1:0] inflight_s;
    logic [NREG-1:0][TNEW_W-1:0] cnt_s;
    logic [NREG-1:0]             err_set_s;
    logic                        hz_rs_s, hz_rt_s, pend_rs_s, pend_rt_s;
    logic                        full_s, stall_s, iss_accept_s;
    logic                        err_q, err_d;

    // Register 0 is hard-wired zero and never pending.
    assign inflight_s[0] = {INFL_W{1'b0}};
    assign cnt_s[0]      = {TNEW_W{1'b0}};
    assign err_set_s[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        grf_scoreboard_sb_entry u_entry (
            .clk_i      (clk),
            .rst_ni     (reset),
            .flush_i    (flush),
            .iss_load_i (iss_accept_s && (iss_rd == ADDR_W'(r))),
            .iss_tnew_i (iss_tnew),
            .wb_hit_i   (wb_we && (wb_a3 == ADDR_W'(r))),
            .inflight_o (inflight_s[r]),
            .cnt_o      (cnt_s[r]),
            .err_set_o  (err_set_s[r])
        );
    end

    // Operand queries and stall decision on current state.
    always_comb begin
        pend_rs_s    = (rs != {ADDR_W{1'b0}}) && (inflight_s[rs] != {INFL_W{1'b0}});
        pend_rt_s    = (rt != {ADDR_W{1'b0}}) && (inflight_s[rt] != {INFL_W{1'b0}});
        hz_rs_s      = pend_rs_s && (cnt_s[rs] > tuse_rs);
        hz_rt_s      = pend_rt_s && (cnt_s[rt] > tuse_rt);
        full_s       = iss_valid && (iss_rd != {ADDR_W{1'b0}}) &&
                       (inflight_s[iss_rd] == INFL_W'(MAX_INFLIGHT));
        stall_s      = hz_rs_s || hz_rt_s || full_s;
        iss_accept_s = iss_valid && !stall_s && !flush;
        err_d        = err_q || (|err_set_s);
    end

    // Sticky write-back-without-writer error; survives flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifdef SB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter: wraps, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign stall  = stall_s;
    assign fwd_rs = pend_rs_s && !hz_rs_s;
    assign fwd_rt = pend_rt_s && !hz_rt_s;
    assign err    = err_q;

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Read-side hazard tracker paired with the general register file.
- Tracks every in-flight register write from decode issue until the write-back write-enable retires it.
- Answers operand queries from the decode stage: stall, or take the value from the bypass network.
- Sits beside the register file in decode; it is the consumer and reader counterpart of the register file's write port (write-enable, destination address).

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- TNEW_W, 2, width of the cycles-until-result countdown.
- MAX_INFLIGHT, 4, maximum outstanding writes per register (pipeline depth).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- flush  in  1  synchronous clear of all entries (exception or branch squash)
- iss_valid  in  1  decode presents an instruction that writes a register
- iss_rd  in  5  destination register of the issuing instruction
- iss_tnew  in  TNEW_W  cycles until its result reaches the bypass network
- rs  in  5  first source operand address
- rt  in  5  second source operand address
- tuse_rs  in  TNEW_W  cycles until rs is consumed
- tuse_rt  in  TNEW_W  cycles until rt is consumed
- wb_we  in  1  write-back write enable (same cycle as the register file write)
- wb_a3  in  5  write-back destination address
- stall  out  1  decode must hold; issue is not accepted
- fwd_rs  out  1  rs pending; take the bypass value, not the register file value
- fwd_rt  out  1  same for rt
- err  out  1  sticky: write-back to a register with zero in-flight writes
- stall_cycles  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- State per register r: inflight[r] (3b, 0..MAX_INFLIGHT) and cnt[r] (TNEW_W). pending[r] = inflight[r] != 0.
- Register 0:
  - Never pending.
  - Issue to register 0 is a no-op.
  - Write-back to register 0 is ignored and does not set err.
- Query logic is combinational on current state:
  - hz_x = pending[x] && cnt[x] > tuse_x
  - fwd_x = pending[x] && !hz_x
  - x = 0 gives hz_x = 0 and fwd_x = 0.
- stall = hz_rs || hz_rt || (iss_valid && iss_rd != 0 && inflight[iss_rd] == MAX_INFLIGHT).
- Issue is accepted when iss_valid && !stall && !flush. On acceptance:
  - inflight[iss_rd] increments.
  - cnt[iss_rd] loads iss_tnew, overriding the decrement; the newest writer defines readiness.
- Every edge, each pending entry not being loaded decrements cnt, saturating at 0.
- Write-back with wb_we && wb_a3 != 0:
  - inflight[wb_a3] decrements.
  - If it reaches 0, cnt clears.
  - If inflight is already 0: no change, err is set.
- Same-edge issue and write-back to the same register: inflight is unchanged and cnt loads iss_tnew.
- flush has priority over issue and write-back:
  - All inflight and cnt are zeroed on the next edge.
  - err is kept.
- Reset low:
  - Asynchronously clears inflight, cnt, err and stall_cycles.
  - Outputs stall = 0, fwd_rs = 0, fwd_rt = 0, err = 0, stall_cycles = 0.
  - Reset mid-stall drops stall immediately.
- Latency: issue and write-back take effect on queries starting the cycle after the edge; there is no same-cycle write-back bypass.

Optional Feature:
- Macro: SB_STALL_CNT_EN.
- Defined: stall_cycles increments on every edge where stall = 1, wraps at 2^32, and is cleared by reset only (not by flush).
- Undefined: stall_cycles is tied to 0 and no counter flops exist.

Decomposition:
- Shared cpu package holds:
  - the register-count constant
  - TNEW_W
  - the Tnew/Tuse encodings (E = 2'd1, M = 2'd2, W = 2'd0) shared with decode
- Natural sub-module sb_entry: one register's inflight/cnt logic, instantiated NREG-1 times.
- Query muxing and the stall counter stay in the top level.

Test Plan:
- Reset low mid-operation with register 5 pending, then high -> stall = 0, fwd_rs = 0, err = 0, and all registers report not pending.
- Issue rd = 8, tnew = 2; next cycle query rs = 8 with tuse = 0 -> stall = 1; cnt reaches 0 two edges after issue -> stall = 0 and fwd_rs = 1; then wb_we with a3 = 8 -> fwd_rs = 0.
- Two issues to rd = 3 (tnew 2, then tnew 0), one write-back -> inflight[3] = 1, rt = 3 with tuse = 0 gives fwd_rt = 1 and no stall; second write-back clears it.
- Issue rd = 9 four times without write-back, fifth iss_valid to rd = 9 -> stall = 1 and inflight stays 4.
- Write-back a3 = 12 with nothing in flight -> err = 1 and stays 1 through flush; issue rd = 0 and query rs = 0 -> stall = 0 and fwd_rs = 0.
- SB_STALL_CNT_EN defined, stall held for 7 cycles then flush -> stall_cycles = 7 and all entries cleared; macro undefined -> stall_cycles = 0 throughout.
